mem_io_initiator: RTL and testbench

- Bus initiator for the word-addressed data-memory / memory-mapped-I/O responder.
- Accepts load/store requests from the core over a valid/ready handshake and drives mem_addr/mem_wdata/mem_we for exactly one access.
- Waits the responder's fixed read latency, captures read data and returns a response over a second valid/ready handshake.
- Filters illegal addresses so the responder never sees them.

---
 rtl/mem_io_initiator_pkg.sv | 24 ++
 rtl/mem_io_initiator_if.sv | 39 +++
 rtl/mem_io_initiator_addr_check.sv | 18 +
 rtl/mem_io_initiator.sv | 96 +++++++++
 tb/tb_mem_io_initiator.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_initiator_pkg.sv
// Shared types and constants for the data-memory / MMIO bus initiator.
package mem_io_initiator_pkg;

    localparam int DATA_W       = 32;
    localparam int IO_SEL_BIT   = 7;
    localparam int WORD_IDX_MSB = 6;
    localparam int WORD_IDX_LSB = 2;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic logic [WORD_IDX_MSB-WORD_IDX_LSB:0] word_idx(
        input word_t a
    );
        return a[WORD_IDX_MSB:WORD_IDX_LSB];
    endfunction

endpackage

// File: rtl/mem_io_initiator_if.sv
// Core request/response handshakes plus the responder-side bus.
interface mem_io_initiator_if;
    import mem_io_initiator_pkg::*;

    logic  req_valid;
    logic  req_ready;
    logic  req_we;
    word_t req_addr;
    word_t req_wdata;

    logic  resp_valid;
    logic  resp_ready;
    word_t resp_rdata;
    logic  resp_err;
    logic  resp_is_io;

    word_t mem_addr;
    word_t mem_wdata;
    logic  mem_we;
    word_t mem_rdata;

    // Environment side: the core plus the memory/IO responder.
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  resp_err, resp_is_io,
        input  mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata,
        output resp_err, resp_is_io,
        output mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/mem_io_initiator_addr_check.sv
// Address legality and I/O-window decode for the word-addressed bus.
module mem_io_addr_check
    import mem_io_initiator_pkg::*;
#(
    parameter int ADDR_LIMIT_BIT = 8
) (
    input  word_t addr,
    output logic  legal,
    output logic  is_io
);

    always_comb begin
        legal = (addr[1:0] == 2'b00)
             && ((addr >> ADDR_LIMIT_BIT) == '0);
        is_io = addr[IO_SEL_BIT];
    end

endmodule

// File: rtl/mem_io_initiator.sv
// Single-outstanding load/store initiator with fixed read latency.
module mem_io_initiator
    import mem_io_initiator_pkg::*;
#(
    parameter int READ_LAT       = 1,
    parameter int ADDR_LIMIT_BIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    mem_io_initiator_if.slave bus
);

    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    state_e     state;
    logic [1:0] cnt;
    logic       we_q;
    logic       legal;
    logic       is_io;

    mem_io_addr_check #(
        .ADDR_LIMIT_BIT(ADDR_LIMIT_BIT)
    ) u_addr_check (
        .addr (bus.req_addr),
        .legal(legal),
        .is_io(is_io)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            we_q           <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.resp_is_io <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_we     <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        we_q           <= bus.req_we;
                        bus.req_ready  <= 1'b0;
                        bus.resp_rdata <= '0;
                        bus.resp_err   <= !legal;
                        bus.resp_is_io <= is_io;
                        // Illegal requests never reach the responder.
                        if (legal) begin
                            bus.mem_addr <= bus.req_addr;
                            if (bus.req_we) begin
                                bus.mem_wdata <= bus.req_wdata;
                            end
                            bus.mem_we <= bus.req_we;
                            state      <= ST_ISSUE;
                        end else begin
                            bus.resp_valid <= 1'b1;
                            state          <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (we_q) begin
                        bus.resp_valid <= 1'b1;
                        state          <= ST_RESP;
                    end else begin
                        cnt   <= CNT_INIT;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 2'd0) begin
                        bus.resp_rdata <= bus.mem_rdata;
                        bus.resp_valid <= 1'b1;
                        state          <= ST_RESP;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_initiator.sv
// Randomized bench: READ_LAT=1 and READ_LAT=3 initiators in lockstep.
module tb_mem_io_initiator;
    import mem_io_initiator_pkg::*;

    localparam int NDUT = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NDUT-1:0] req_valid;
    logic [NDUT-1:0] req_we;
    logic [NDUT-1:0] resp_ready;
    word_t           req_addr  [NDUT];
    word_t           req_wdata [NDUT];

    logic [NDUT-1:0] o_req_ready;
    logic [NDUT-1:0] o_resp_valid;
    logic [NDUT-1:0] o_resp_err;
    logic [NDUT-1:0] o_resp_is_io;
    logic [NDUT-1:0] o_mem_we;
    word_t           o_resp_rdata [NDUT];
    word_t           o_mem_addr   [NDUT];
    word_t           o_mem_wdata  [NDUT];

    int    n_chk  = 0;
    int    n_fail = 0;
    int    n_we_rst = 0;
    word_t ref_mem [64];

    function automatic word_t init_word(input int i);
        return 32'h5A00_0000 ^ (word_t'(i) * 32'h0001_0203);
    endfunction

    function automatic int rl_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        mem_io_initiator_if bus();
        word_t mem  [64];
        word_t pipe [4];

        assign bus.req_valid  = req_valid[g];
        assign bus.req_we     = req_we[g];
        assign bus.req_addr   = req_addr[g];
        assign bus.req_wdata  = req_wdata[g];
        assign bus.resp_ready = resp_ready[g];
        assign bus.mem_rdata  = pipe[L-1];

        assign o_req_ready[g]  = bus.req_ready;
        assign o_resp_valid[g] = bus.resp_valid;
        assign o_resp_err[g]   = bus.resp_err;
        assign o_resp_is_io[g] = bus.resp_is_io;
        assign o_mem_we[g]     = bus.mem_we;
        assign o_resp_rdata[g] = bus.resp_rdata;
        assign o_mem_addr[g]   = bus.mem_addr;
        assign o_mem_wdata[g]  = bus.mem_wdata;

        initial begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            for (int i = 0; i < 4; i++) pipe[i] <= 32'hBAD0_0000;
        end

        // Responder: registered read, data appears L cycles after address.
        always @(posedge clock) begin
            if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            pipe[0] <= mem[bus.mem_addr[7:2]];
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        mem_io_initiator #(
            .READ_LAT      (L),
            .ADDR_LIMIT_BIT(8)
        ) dut (
            .clock(clock),
            .reset(reset),
            .bus  (bus)
        );
    end

    always @(posedge clock) begin
        if (reset && (o_mem_we != '0)) n_we_rst <= n_we_rst + 1;
    end

    task automatic chk(input string tag, input int k,
                       input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            chk({tag, "_req_ready"}, k, o_req_ready[k], 1);
            chk({tag, "_resp_valid"}, k, o_resp_valid[k], 0);
            chk({tag, "_resp_rdata"}, k, o_resp_rdata[k], 0);
            chk({tag, "_resp_err"}, k, o_resp_err[k], 0);
            chk({tag, "_resp_is_io"}, k, o_resp_is_io[k], 0);
            chk({tag, "_mem_addr"}, k, o_mem_addr[k], 0);
            chk({tag, "_mem_wdata"}, k, o_mem_wdata[k], 0);
            chk({tag, "_mem_we"}, k, o_mem_we[k], 0);
        end
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (o_req_ready != '1 && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk("req_ready_wait", -1, 32'(o_req_ready), 32'h3);
    endtask

    task automatic txn(input logic we, input word_t addr,
                       input word_t wdata, input int bp);
        logic  legal;
        logic  isio;
        word_t exp_rd;
        int    lat     [NDUT];
        word_t prev_ma [NDUT];
        bit    done    [NDUT];
        bit    post    [NDUT];
        int    nwe     [NDUT];
        int    c;
        legal  = (addr[1:0] == 2'b00) && (addr[31:8] == 24'h0);
        isio   = addr[7];
        exp_rd = (legal && !we) ? ref_mem[addr[7:2]] : 32'h0;
        wait_ready();
        for (int k = 0; k < NDUT; k++) begin
            lat[k]     = !legal ? 1 : (we ? 2 : 2 + rl_of(k));
            prev_ma[k] = o_mem_addr[k];
            done[k]    = 1'b0;
            post[k]    = 1'b0;
            nwe[k]     = 0;
            req_valid[k]  = 1'b1;
            req_we[k]     = we;
            req_addr[k]   = addr;
            req_wdata[k]  = wdata;
            resp_ready[k] = 1'b0;
        end
        c = 0;
        while (!(post[0] && post[1]) && c < 60) begin
            @(negedge clock);
            c++;
            for (int k = 0; k < NDUT; k++) begin
                if (!done[k]) begin
                    chk("busy_req_ready", k, o_req_ready[k], 0);
                    chk("resp_valid", k, o_resp_valid[k], 32'(c >= lat[k]));
                    if (o_resp_valid[k]) begin
                        chk("resp_rdata", k, o_resp_rdata[k], exp_rd);
                        chk("resp_err", k, o_resp_err[k], !legal);
                        chk("resp_is_io", k, o_resp_is_io[k], isio);
                    end
                    chk("mem_we", k, o_mem_we[k], legal && we && c == 1);
                    if (o_mem_we[k]) begin
                        nwe[k]++;
                        chk("we_addr", k, o_mem_addr[k], addr);
                        chk("we_wdata", k, o_mem_wdata[k], wdata);
                    end
                    if (legal && c < lat[k])
                        chk("mem_addr_hold", k, o_mem_addr[k], addr);
                    if (!legal)
                        chk("err_mem_addr", k, o_mem_addr[k], prev_ma[k]);
                    // Junk request stays asserted to prove it is ignored.
                    req_valid[k]  = 1'b1;
                    req_we[k]     = 1'($urandom);
                    req_addr[k]   = $urandom & 32'hFC;
                    req_wdata[k]  = $urandom;
                    resp_ready[k] = (c >= lat[k] + bp);
                    if (o_resp_valid[k] && resp_ready[k]) done[k] = 1'b1;
                end else if (!post[k]) begin
                    chk("resp_drop", k, o_resp_valid[k], 0);
                    chk("back_idle", k, o_req_ready[k], 1);
                    req_valid[k]  = 1'b0;
                    resp_ready[k] = 1'b0;
                    post[k]       = 1'b1;
                end
            end
        end
        chk("txn_done", -1, 32'({post[1], post[0]}), 32'h3);
        for (int k = 0; k < NDUT; k++)
            chk("we_pulses", k, nwe[k], 32'(legal && we));
        if (legal && we) ref_mem[addr[7:2]] = wdata;
    endtask

    task automatic abort_txn(input logic we, input word_t addr,
                             input word_t wdata, input int at_c);
        int rst_base;
        wait_ready();
        for (int k = 0; k < NDUT; k++) begin
            req_valid[k] = 1'b1;
            req_we[k]    = we;
            req_addr[k]  = addr;
            req_wdata[k] = wdata;
        end
        @(negedge clock);
        req_valid = '0;
        repeat (at_c - 1) @(negedge clock);
        for (int k = 0; k < NDUT; k++) begin
            chk("pre_rst_we", k, o_mem_we[k], 32'(we && at_c == 1));
            chk("pre_rst_addr", k, o_mem_addr[k], addr);
        end
        rst_base = n_we_rst;
        #2 reset = 1'b1;
        #1 chk_idle_outputs("async_rst");
        @(negedge clock);
        @(negedge clock);
        chk("we_in_reset", -1, n_we_rst - rst_base, 0);
        reset = 1'b0;
        @(negedge clock);
        for (int k = 0; k < NDUT; k++)
            chk("post_rst_ready", k, o_req_ready[k], 1);
    endtask

    initial begin
        logic  we;
        word_t addr;
        int    r;
        req_valid  = '0;
        req_we     = '0;
        resp_ready = '0;
        for (int k = 0; k < NDUT; k++) begin
            req_addr[k]  = '0;
            req_wdata[k] = '0;
        end
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        repeat (2) @(negedge clock);
        chk_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        txn(1'b1, 32'h14, 32'hDEAD_BEEF, 0);
        txn(1'b0, 32'h14, 32'h0, 0);
        txn(1'b1, 32'h80, 32'h0000_001F, 0);
        txn(1'b0, 32'h16, 32'h0, 0);
        txn(1'b1, 32'h100, 32'h1234_5678, 0);
        txn(1'b1, 32'h84, 32'h0000_0003, 0);
        txn(1'b0, 32'h84, 32'h0, 5);
        txn(1'b0, 32'h08, 32'h0, 0);
        txn(1'b1, 32'h20, 32'h1111_2222, 0);

        abort_txn(1'b0, 32'h08, 32'h0, 2);
        abort_txn(1'b1, 32'h20, 32'hCAFE_F00D, 1);
        txn(1'b0, 32'h20, 32'h0, 1);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            we = 1'($urandom);
            if (r == 0)
                addr = ($urandom & 32'hFC) | 32'($urandom_range(1, 3));
            else if (r == 1)
                addr = ($urandom & 32'hFC)
                     | (32'h100 << $urandom_range(0, 23));
            else
                addr = $urandom & 32'hFC;
            txn(we, addr, $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
